// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encoding,
// the hard-wired zero register and the instruction that a flushed stage register holds.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_REDIRECT = 2'd2
   } ctrl_state_t;

   localparam logic [4:0]  REG_X0    = 5'd0;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register that the instruction
// in ID reads. Writes to x0 are discarded by the register file, so they never hazard.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs1_reg,
   input  logic [4:0] rs2_reg,
   input  logic       uses_rs2,
   input  logic       mem_read,
   input  logic [4:0] rd_reg,
   output logic       hit
);

   always_comb begin
      hit = 1'b0;
      if (mem_read && (rd_reg != REG_X0)) begin
         hit = (rd_reg == rs1_reg) || (uses_rs2 && (rd_reg == rs2_reg));
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX and EX/MEM registers and the PC.
// Priority each cycle: data-memory freeze, then branch/jump redirect, then load-use stall.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 64,
   parameter int STALL_CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4:0]             ID_rs1Reg,
   input  logic [4:0]             ID_rs2Reg,
   input  logic                   ID_UsesRs2,
   input  logic                   EX_MemRead,
   input  logic [4:0]             EX_rdReg,
   input  logic                   EX_Redirect,
   input  logic                   MEM_MemReq,
   input  logic                   MEM_MemReady,
   output logic                   PC_Write,
   output logic                   IF_ID_Write,
   output logic                   IF_ID_Flush,
   output logic                   ID_EX_Write,
   output logic                   ID_EX_Bubble,
   output logic                   EX_MEM_Hold,
   output logic                   MemTimeout,
   output logic [STALL_CNT_W-1:0] StallCount
);

   localparam int              FC_W         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [15:0]     TIMEOUT_LIM  = 16'(MEM_TIMEOUT);

   ctrl_state_t            state_q, state_d;
   logic [FC_W-1:0]        flush_cnt_q, flush_cnt_d;
   logic [15:0]            wait_cnt_q, wait_cnt_d;
   logic                   timeout_q;
   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic                   freeze;
   logic                   residual;
   logic                   load_use;

   function automatic logic [15:0] sat_inc_wait(input logic [15:0] v);
      return (v == '1) ? v : v + 16'd1;
   endfunction

   function automatic logic [STALL_CNT_W-1:0] sat_inc_stall(input logic [STALL_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   hazard_detect u_hazard_detect (
      .rs1_reg  (ID_rs1Reg),
      .rs2_reg  (ID_rs2Reg),
      .uses_rs2 (ID_UsesRs2),
      .mem_read (EX_MemRead),
      .rd_reg   (EX_rdReg),
      .hit      (load_use)
   );

   assign freeze   = MEM_MemReq & ~MEM_MemReady;
   // A redirect interrupted by a freeze keeps its remaining flush cycles in MEM_WAIT.
   assign residual = (state_q == ST_REDIRECT) ||
                     ((state_q == ST_MEM_WAIT) && (flush_cnt_q != '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= '0;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         if (freeze && (wait_cnt_d >= TIMEOUT_LIM)) begin
            timeout_q <= 1'b1;
         end
         if (!PC_Write) begin
            stall_cnt_q <= sat_inc_stall(stall_cnt_q);
         end
      end
   end

   always_comb begin
      state_d     = ST_RUN;
      flush_cnt_d = flush_cnt_q;
      wait_cnt_d  = '0;
      if (freeze) begin
         state_d    = ST_MEM_WAIT;
         wait_cnt_d = sat_inc_wait(wait_cnt_q);
      end else if (EX_Redirect) begin
         flush_cnt_d = FLUSH_RELOAD;
         state_d     = (FLUSH_RELOAD != '0) ? ST_REDIRECT : ST_RUN;
      end else if (residual) begin
         flush_cnt_d = flush_cnt_q - 1'b1;
         state_d     = (flush_cnt_q > FC_W'(1)) ? ST_REDIRECT : ST_RUN;
      end
   end

   always_comb begin
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Write  = 1'b1;
      ID_EX_Bubble = 1'b0;
      EX_MEM_Hold  = 1'b0;
      if (rst) begin
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (freeze) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Write = 1'b0;
         EX_MEM_Hold = 1'b1;
      end else if (EX_Redirect || residual) begin
         // Wrong-path instructions in IF/ID and ID are squashed; any load-use there is moot.
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (load_use) begin
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end
   end

   assign MemTimeout = timeout_q;
   assign StallCount = stall_cnt_q;

endmodule
